// File: rtl/sub_pkg.sv
// ============================================================================
// Module      : sub_pkg
// Description : Shared types and sizing helpers for the chunked subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk operation still needs a 1-bit counter to stay legal.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sub_chunk.sv
// ============================================================================
// Module      : sub_chunk
// Description : Combinational CHUNK-bit subtract with borrow in and borrow out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);

    // One extra bit captures the borrow as the wrapped sign of the difference.
    assign {bout, d} = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};

endmodule

`default_nettype wire

// File: rtl/sub_iter_chunked.sv
// ============================================================================
// Module      : sub_iter_chunked
// Description : Multi-cycle D = A - B - B_in, CHUNK bits per clock, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub_iter_chunked
    import sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             B_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             B_out,
    output logic             V
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int CW     = cnt_width(NCHUNK);

    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $error("sub_iter_chunked: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  a_work;
    logic [WIDTH-1:0]  b_work;
    logic              bor;
    logic [CW-1:0]     cnt;
    logic              a_msb;
    logic              b_msb;
    logic [CHUNK-1:0]  d_chunk;
    logic              bout_chunk;
    logic [WIDTH-1:0]  res_next;
    logic              last;
    logic              accept;

    assign last   = (cnt == CW'(NCHUNK - 1));
    assign accept = start && (state != RUN);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    sub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a    (a_work[CHUNK-1:0]),
        .b    (b_work[CHUNK-1:0]),
        .bin  (bor),
        .d    (d_chunk),
        .bout (bout_chunk)
    );

    // Result chunks enter at the top and shift down, so after the last
    // chunk the LSB chunk sits at bit 0.
    generate
        if (NCHUNK > 1) begin : g_multi
            logic [WIDTH-1:0] work;
            assign res_next = {d_chunk, work[WIDTH-1:CHUNK]};
            always_ff @(posedge clk) begin
                if (rst) begin
                    work <= '0;
                end else if (state == RUN) begin
                    work <= res_next;
                end
            end
        end else begin : g_single
            assign res_next = d_chunk;
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_work <= '0;
            b_work <= '0;
            bor    <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            D      <= '0;
            B_out  <= 1'b0;
            V      <= 1'b0;
        end else if (accept) begin
            a_work <= A;
            b_work <= B;
            bor    <= B_in;
            cnt    <= '0;
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
        end else if (state == RUN) begin
            a_work <= a_work >> CHUNK;
            b_work <= b_work >> CHUNK;
            bor    <= bout_chunk;
            cnt    <= cnt + 1'b1;
            if (last) begin
                D     <= res_next;
                B_out <= bout_chunk;
                V     <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
            end
        end
    end

endmodule

`default_nettype wire
